// File: rtl/cic_pdm_decimator.sv
// CIC decimator for a 1-bit PDM microphone stream. It produces signed PCM at fs/2^DECIM_LOG2
// through an ORDER-stage pipelined integrator chain and a comb chain that runs on each
// decimation tick. The comb result is scaled and saturated into a single-entry output
// register that uses a valid/ready handshake.
//
// Ports:
//   clk          PDM bit clock (only clock)
//   rst_n        asynchronous active-low reset
//   pdm_en       sample enable; pdm_in consumed only when high
//   pdm_in       PDM bit, 1 -> +1, 0 -> -1
//   pcm_out      signed PCM sample, stable while pcm_valid is high
//   pcm_valid    sample available
//   pcm_ready    consumer accepts on pcm_valid & pcm_ready
//   overrun      sticky: an unaccepted sample was overwritten
//   overrun_clr  synchronous clear of overrun (a coincident set wins)
module cic_pdm_decimator #(
    parameter int unsigned ORDER      = 3,
    parameter int unsigned DECIM_LOG2 = 6,
    parameter int unsigned OUT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pdm_en,
    input  logic                 pdm_in,
    output logic [OUT_WIDTH-1:0] pcm_out,
    output logic                 pcm_valid,
    input  logic                 pcm_ready,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int unsigned W  = ORDER * DECIM_LOG2 + 2;
    localparam int unsigned S  = ORDER * DECIM_LOG2 - OUT_WIDTH + 1;
    localparam int unsigned UW = W - OUT_WIDTH + 1;
    localparam int unsigned SW = $clog2(ORDER + 1);

    logic [W-1:0]          integ_q  [ORDER];
    logic [W-1:0]          dly_q    [ORDER];
    logic [W-1:0]          stage_in [ORDER];
    logic [W-1:0]          comb_acc;
    logic [W-1:0]          comb_last;
    logic [W-1:0]          step_val;
    logic [W-1:0]          shifted;
    logic [UW-1:0]         upper;
    logic [OUT_WIDTH-1:0]  sample;
    logic [DECIM_LOG2-1:0] cnt_q;
    logic [SW-1:0]         settle_q;
    logic                  settled;
    logic                  tick;
    logic                  emit;

    assign step_val = pdm_in ? W'(1) : '1;
    assign tick     = pdm_en && (cnt_q == '1);
    assign settled  = (settle_q == SW'(ORDER));
    assign emit     = tick && settled;

    // Comb chain from pre-edge state; stage_in[k] is what d[k] captures on the tick.
    always_comb begin
        comb_acc = integ_q[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            stage_in[k] = comb_acc;
            comb_acc    = comb_acc - dly_q[k];
        end
        comb_last = comb_acc;
    end

    // Floor scaling; any upper bit disagreeing with the sign means out of range.
    always_comb begin
        shifted = W'($signed(comb_last) >>> S);
        upper   = shifted[W-1:OUT_WIDTH-1];
        sample  = shifted[OUT_WIDTH-1:0];
        if (!((&upper) || !(|upper))) begin
            sample = shifted[W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    // Integrators, combs, decimation and settle counters; everything holds when pdm_en=0.
    // Integrator wrap modulo 2^W is intentional and cancelled by the combs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            cnt_q    <= '0;
            settle_q <= '0;
        end else if (pdm_en) begin
            integ_q[0] <= integ_q[0] + step_val;
            for (int k = 1; k < ORDER; k++) begin
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
            cnt_q <= cnt_q + 1'b1;
            if (tick) begin
                for (int k = 0; k < ORDER; k++) begin
                    dly_q[k] <= stage_in[k];
                end
                if (!settled) begin
                    settle_q <= settle_q + 1'b1;
                end
            end
        end
    end

    // Single-entry output register with valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else if (emit) begin
            pcm_out   <= sample;
            pcm_valid <= 1'b1;
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (emit && pcm_valid && !pcm_ready) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_pdm_decimator.sv
// Directed bench for cic_pdm_decimator: default build (ORDER=3, R=64, OUT_WIDTH=16) plus a
// small build (ORDER=1, R=16, OUT_WIDTH=5) that shares the stimulus.
module tb_cic_pdm_decimator;

    logic        clk;
    logic        rst_n;
    logic        pdm_en;
    logic        pdm_in;
    logic        pcm_ready;
    logic        overrun_clr;
    logic [15:0] pcm_out;
    logic        pcm_valid;
    logic        overrun;
    logic [4:0]  s_pcm_out;
    logic        s_pcm_valid;
    logic        s_overrun;

    int errors;
    int checks;
    int en_cnt;

    cic_pdm_decimator #(.ORDER(3), .DECIM_LOG2(6), .OUT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .pdm_en(pdm_en), .pdm_in(pdm_in),
        .pcm_out(pcm_out), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    cic_pdm_decimator #(.ORDER(1), .DECIM_LOG2(4), .OUT_WIDTH(5)) dut_small (
        .clk(clk), .rst_n(rst_n), .pdm_en(pdm_en), .pdm_in(pdm_in),
        .pcm_out(s_pcm_out), .pcm_valid(s_pcm_valid), .pcm_ready(pcm_ready),
        .overrun(s_overrun), .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (pdm_en) en_cnt++;
    endtask

    task automatic do_reset();
        pdm_en = 1'b0; pdm_in = 1'b0; pcm_ready = 1'b0; overrun_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en_cnt = 0;
    endtask

    // Run enabled edges until the next edge is a tick (counter == 63).
    task automatic adv_until_tick();
        pdm_en = 1'b1;
        while (en_cnt % 64 != 63) step();
    endtask

    task automatic test_reset();
        pdm_en = 1'b1; pdm_in = 1'b1; pcm_ready = 1'b1; overrun_clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pcm_out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", pcm_out); end
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pcm_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        // pdm_en low: nothing may advance, so no sample can ever appear.
        pdm_en = 1'b0;
        rst_n = 1'b1;
        en_cnt = 0;
        repeat (300) begin
            step();
            checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b expected 0", pcm_valid); end
        end
    endtask

    // pat: 0 constant 1, 1 constant 0, 2 alternating starting with 1. gate: pdm_en toggles.
    task automatic test_stream(input int pat, input bit gate, input int nticks,
                               input logic [15:0] expv, input string name);
        int   cyc;
        int   last;
        int   emitted;
        int   spacing;
        logic en;
        logic exp_valid;
        do_reset();
        pcm_ready = 1'b1;
        cyc = 0; last = -1; emitted = 0;
        spacing = gate ? 128 : 64;
        while (en_cnt < nticks * 64) begin
            en = gate ? (cyc % 2 == 0) : 1'b1;
            pdm_en = en;
            pdm_in = (pat == 0) ? 1'b1 : (pat == 1) ? 1'b0 : (en_cnt % 2 == 0);
            exp_valid = en && (en_cnt % 64 == 63) && (en_cnt / 64 >= 3);
            step();
            cyc++;
            checks++;
            if (pcm_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s_valid cyc %0d: got %b expected %b", name, cyc, pcm_valid, exp_valid);
            end
            if (exp_valid) begin
                emitted++;
                checks++;
                if (pcm_out !== expv) begin
                    errors++;
                    $display("FAIL %s_value cyc %0d: got %0d expected %0d", name, cyc,
                             $signed(pcm_out), $signed(expv));
                end
                checks++;
                if (overrun !== 1'b0) begin errors++; $display("FAIL %s_overrun: got %b expected 0", name, overrun); end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != spacing) begin
                        errors++;
                        $display("FAIL %s_spacing: got %0d expected %0d", name, cyc - last, spacing);
                    end
                end
                last = cyc;
            end
        end
        pdm_en = 1'b0;
        checks++;
        if (emitted != nticks - 3) begin
            errors++;
            $display("FAIL %s_count: got %0d expected %0d", name, emitted, nticks - 3);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        pdm_en = 1'b1; pdm_in = 1'b1; pcm_ready = 1'b0;
        repeat (4) begin adv_until_tick(); step(); end
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b expected 1", pcm_valid); end
        checks++; if (pcm_out !== 16'h7FFF) begin errors++; $display("FAIL ovr_first_out: got %h expected 7fff", pcm_out); end
        pdm_in = 1'b0;
        adv_until_tick();
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid: got %b expected 1", pcm_valid); end
        checks++; if (pcm_out !== 16'h7FFF) begin errors++; $display("FAIL ovr_held_out: got %h expected 7fff", pcm_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b expected 0", overrun); end
        step();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL ovr_set_valid: got %b expected 1", pcm_valid); end
        repeat (3) begin adv_until_tick(); step(); end
        checks++; if (pcm_out !== 16'h8000) begin errors++; $display("FAIL ovr_overwrite: got %h expected 8000", pcm_out); end
        pcm_ready = 1'b1;
        step();
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_valid: got %b expected 0", pcm_valid); end
        checks++; if (pcm_out !== 16'h8000) begin errors++; $display("FAIL ovr_accept_hold: got %h expected 8000", pcm_out); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        pcm_ready = 1'b0; overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        adv_until_tick(); step();
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL ovr_reload_valid: got %b expected 1", pcm_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_reload: got %b expected 0", overrun); end
        adv_until_tick();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", overrun); end
        pdm_en = 1'b0;
    endtask

    // Input is -1 for ticks 1..4 then +1; tick 6 straddles the step (20792), tick 7 is 32767.
    task automatic test_back_to_back();
        do_reset();
        pdm_en = 1'b1; pdm_in = 1'b0; pcm_ready = 1'b1;
        repeat (4) begin adv_until_tick(); step(); end
        checks++; if (pcm_out !== 16'h8000) begin errors++; $display("FAIL b2b_neg: got %h expected 8000", pcm_out); end
        pdm_in = 1'b1;
        adv_until_tick(); step();
        adv_until_tick();
        pcm_ready = 1'b0;
        step();
        checks++; if (pcm_out !== 16'd20792) begin errors++; $display("FAIL b2b_tick6: got %0d expected 20792", $signed(pcm_out)); end
        adv_until_tick();
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL b2b_held: got %b expected 1", pcm_valid); end
        pcm_ready = 1'b1;
        step();
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", pcm_valid); end
        checks++; if (pcm_out !== 16'h7FFF) begin errors++; $display("FAIL b2b_new: got %h expected 7fff", pcm_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        step();
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", pcm_valid); end
        pdm_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic exp_valid;
        do_reset();
        pdm_en = 1'b1; pdm_in = 1'b1; pcm_ready = 1'b0;
        while (en_cnt < 4 * 64 + 30) step();
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", pcm_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pcm_out !== 16'h0000) begin errors++; $display("FAIL mid_async_out: got %h expected 0000", pcm_out); end
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", pcm_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en_cnt = 0;
        pcm_ready = 1'b1;
        while (en_cnt < 5 * 64) begin
            exp_valid = (en_cnt % 64 == 63) && (en_cnt / 64 >= 3);
            if (en_cnt == 255) begin
                checks++;
                if (pcm_out !== 16'h0000) begin errors++; $display("FAIL mid_stale: got %h expected 0000", pcm_out); end
            end
            step();
            checks++;
            if (pcm_valid !== exp_valid) begin
                errors++;
                $display("FAIL mid_valid en %0d: got %b expected %b", en_cnt, pcm_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (pcm_out !== 16'h7FFF) begin errors++; $display("FAIL mid_value: got %h expected 7fff", pcm_out); end
            end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b expected 0", overrun); end
        pdm_en = 1'b0;
    endtask

    // ORDER=1, R=16: full scale 16 saturates to 15; first sample at tick 2.
    task automatic test_small_config();
        int   emitted;
        logic exp_valid;
        do_reset();
        pdm_en = 1'b1; pdm_in = 1'b1; pcm_ready = 1'b1;
        emitted = 0;
        while (en_cnt < 6 * 16) begin
            exp_valid = (en_cnt % 16 == 15) && (en_cnt / 16 >= 1);
            step();
            checks++;
            if (s_pcm_valid !== exp_valid) begin
                errors++;
                $display("FAIL small_valid en %0d: got %b expected %b", en_cnt, s_pcm_valid, exp_valid);
            end
            if (exp_valid) begin
                emitted++;
                checks++;
                if (s_pcm_out !== 5'd15) begin errors++; $display("FAIL small_value: got %0d expected 15", s_pcm_out); end
            end
        end
        checks++; if (emitted != 5) begin errors++; $display("FAIL small_count: got %0d expected 5", emitted); end
        checks++; if (s_overrun !== 1'b0) begin errors++; $display("FAIL small_overrun: got %b expected 0", s_overrun); end
        pdm_en = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; en_cnt = 0;
        rst_n = 1'b0; pdm_en = 1'b0; pdm_in = 1'b0; pcm_ready = 1'b0; overrun_clr = 1'b0;
        test_reset();
        test_stream(0, 1'b0, 8, 16'h7FFF, "pos");
        test_stream(1, 1'b0, 6, 16'h8000, "neg");
        test_stream(2, 1'b0, 6, 16'h0000, "alt");
        test_stream(0, 1'b1, 6, 16'h7FFF, "gated");
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        test_small_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
